// File: rtl/mem_access_unit.sv
// Load/store unit between a RISC-V core and a single-port word-wide data memory.
// Handles LB/LH/LW/LBU/LHU and SB/SH/SW; sub-word stores use read-modify-write.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic        write_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, merged_q;
  logic [31:0] word_addr;
  logic        accept;

  // Unsigned widths are only legal for loads; misalignment depends on access size.
  function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = a[0];
      F3_W:    e = (a != 2'b00);
      F3_BU:   e = wr;
      F3_HU:   e = wr | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word, input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B: m[{a, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (a[1]) m[31:16] = wdata[15:0];
        else      m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign word_addr = {addr_q[31:2], 2'b00};
  assign accept    = req_valid && req_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state_q)
      IDLE: begin
        req_ready = reset;
        if (req_valid && reset) begin
          if (access_err(req_write, req_funct3, req_addr[1:0])) state_d = RESP;
          else if (!req_write)                                  state_d = RD;
          else if (req_funct3 == F3_W)                          state_d = WR;
          else                                                  state_d = RMW_RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        mem_addr = word_addr;
        state_d  = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = word_addr;
        state_d  = WR;
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = word_addr;
        mem_din   = merged_q;
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= access_err(req_write, req_funct3, req_addr[1:0]);
            merged_q <= req_wdata;
          end
        end
        RD:     resp_rdata <= extract_load(funct3_q, addr_q[1:0], mem_dout);
        RMW_RD: merged_q   <= merge_store(funct3_q, addr_q[1:0], mem_dout, wdata_q);
        RESP: begin
          // The pulse is registered out of RESP, so it appears in the following IDLE cycle.
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          if (write_q || err_q) resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
